// File: rtl/gbe_tx_frame_counter.sv
// Transmit-side statistics for the 10GbE core: good frames, words sent, and errors
// (runt/oversize frames plus tx overflow edges), one of them muxed onto a status word.
module gbe_tx_frame_counter #(
    parameter int CNT_W     = 32,
    parameter int LEN_W     = 16,
    parameter int MIN_WORDS = 8,
    parameter int MAX_WORDS = 1024,
    parameter int SATURATE  = 0
) (
    input  logic             user_clk,
    input  logic             user_rst,
    input  logic             tx_valid,
    input  logic             tx_end_of_frame,
    input  logic             tx_overflow,
    input  logic             ctrl_en,
    input  logic             ctrl_clr,
    input  logic [1:0]       ctrl_sel,
    output logic [CNT_W-1:0] cnt_out
);

    typedef enum logic {IDLE = 1'b0, IN_FRAME = 1'b1} state_t;

    localparam logic [LEN_W:0] MIN_L = (LEN_W+1)'(MIN_WORDS);
    localparam logic [LEN_W:0] MAX_L = (LEN_W+1)'(MAX_WORDS);

    state_t           state_reg, state_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic [LEN_W:0]   frame_len;
    logic             frame_end;
    logic             frame_good;
    logic             ovf_d_reg;
    logic             clr_d_reg;
    logic             clr_pulse;
    logic             ovf_edge;
    logic [1:0]       cnt_inc [3];
    logic [CNT_W-1:0] cnt_val [3];
    logic [CNT_W-1:0] cnt_out_reg;

    // Framing is tracked even while counting is disabled so enable can change mid-frame.
    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        frame_end  = 1'b0;
        frame_len  = '0;
        case (state_reg)
            IDLE: begin
                if (tx_valid) begin
                    if (tx_end_of_frame) begin
                        frame_end = 1'b1;
                        frame_len = {{LEN_W{1'b0}}, 1'b1};
                    end else begin
                        state_next = IN_FRAME;
                        len_next   = {{(LEN_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            IN_FRAME: begin
                if (tx_valid) begin
                    if (tx_end_of_frame) begin
                        frame_end  = 1'b1;
                        frame_len  = {1'b0, len_reg} + 1'b1;
                        state_next = IDLE;
                        len_next   = '0;
                    end else if (len_reg != {LEN_W{1'b1}}) begin
                        len_next = len_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_reg <= IDLE;
            len_reg   <= '0;
            ovf_d_reg <= 1'b0;
            clr_d_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            ovf_d_reg <= tx_overflow;
            clr_d_reg <= ctrl_clr;
        end
    end

    assign frame_good = (frame_len >= MIN_L) && (frame_len <= MAX_L);
    assign ovf_edge   = tx_overflow & ~ovf_d_reg;
    assign clr_pulse  = ctrl_clr & ~clr_d_reg;

    // A bad frame end and an overflow edge in the same cycle both land on err (+2).
    assign cnt_inc[0] = {1'b0, ctrl_en & frame_end & frame_good};
    assign cnt_inc[1] = {1'b0, ctrl_en & tx_valid};
    assign cnt_inc[2] = {1'b0, ctrl_en & frame_end & ~frame_good} + {1'b0, ctrl_en & ovf_edge};

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] cur, input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cur} + {{(CNT_W-1){1'b0}}, inc};
        if (SATURATE != 0 && sum[CNT_W])
            bump = {CNT_W{1'b1}};
        else
            bump = sum[CNT_W-1:0];
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            // Clear has priority over any increment in the same cycle.
            always_ff @(posedge user_clk) begin
                if (user_rst || clr_pulse)
                    cnt_reg <= '0;
                else
                    cnt_reg <= bump(cnt_reg, cnt_inc[gi]);
            end
            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            cnt_out_reg <= '0;
        end else begin
            case (ctrl_sel)
                2'd0:    cnt_out_reg <= cnt_val[0];
                2'd1:    cnt_out_reg <= cnt_val[1];
                2'd2:    cnt_out_reg <= cnt_val[2];
                default: cnt_out_reg <= {{(CNT_W-3){1'b0}}, (state_reg == IN_FRAME), ctrl_en, ovf_d_reg};
            endcase
        end
    end

    assign cnt_out = cnt_out_reg;

endmodule

// File: tb/tb_gbe_tx_frame_counter.sv
// Bench for gbe_tx_frame_counter: three variants (32-bit wrap, 8-bit wrap, 8-bit saturate)
// share one stimulus stream and are compared every cycle against a word-counting model.
module tb_gbe_tx_frame_counter;

    logic       user_clk = 1'b0;
    logic       user_rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic       tx_end_of_frame = 1'b0;
    logic       tx_overflow = 1'b0;
    logic       ctrl_en = 1'b0;
    logic       ctrl_clr = 1'b0;
    logic [1:0] ctrl_sel = 2'd0;
    logic [31:0] out32;
    logic [7:0]  out8w;
    logic [7:0]  out8s;

    always #5 user_clk = ~user_clk;

    gbe_tx_frame_counter dut32 (
        .user_clk(user_clk), .user_rst(user_rst), .tx_valid(tx_valid),
        .tx_end_of_frame(tx_end_of_frame), .tx_overflow(tx_overflow), .ctrl_en(ctrl_en),
        .ctrl_clr(ctrl_clr), .ctrl_sel(ctrl_sel), .cnt_out(out32)
    );

    gbe_tx_frame_counter #(.CNT_W(8), .SATURATE(0)) dut8w (
        .user_clk(user_clk), .user_rst(user_rst), .tx_valid(tx_valid),
        .tx_end_of_frame(tx_end_of_frame), .tx_overflow(tx_overflow), .ctrl_en(ctrl_en),
        .ctrl_clr(ctrl_clr), .ctrl_sel(ctrl_sel), .cnt_out(out8w)
    );

    gbe_tx_frame_counter #(.CNT_W(8), .SATURATE(1)) dut8s (
        .user_clk(user_clk), .user_rst(user_rst), .tx_valid(tx_valid),
        .tx_end_of_frame(tx_end_of_frame), .tx_overflow(tx_overflow), .ctrl_en(ctrl_en),
        .ctrl_clr(ctrl_clr), .ctrl_sel(ctrl_sel), .cnt_out(out8s)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: true event counts since the last clear, plus words seen in the open frame.
    longint m_frm = 0, m_wrd = 0, m_err = 0;
    int     m_len = 0;
    bit     m_ovf_d = 0, m_clr_d = 0;

    typedef struct {
        int     len;
        bit     en;
        longint frm;
        longint wrd;
        longint err;
    } vec_t;
    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input longint e);
        logic [63:0] e8s;
        e8s = (e > 255) ? 64'd255 : 64'(e);
        chk({name, "_w32"}, {32'd0, out32}, 64'(e) & 64'hFFFF_FFFF);
        chk({name, "_w8"},  {56'd0, out8w}, 64'(e) & 64'hFF);
        chk({name, "_s8"},  {56'd0, out8s}, e8s);
    endtask

    // Advance one clock with the currently driven inputs and check the expected cnt_out.
    task automatic tick();
        longint e;
        bit     pulse, ovf_rise;
        int     flen;
        if (user_rst) begin
            e = 0;
        end else begin
            case (ctrl_sel)
                2'd0:    e = m_frm;
                2'd1:    e = m_wrd;
                2'd2:    e = m_err;
                default: e = (m_len > 0 ? 4 : 0) + (ctrl_en ? 2 : 0) + (m_ovf_d ? 1 : 0);
            endcase
        end
        if (user_rst) begin
            m_frm = 0; m_wrd = 0; m_err = 0; m_len = 0; m_ovf_d = 0; m_clr_d = 0;
        end else begin
            pulse    = ctrl_clr && !m_clr_d;
            ovf_rise = tx_overflow && !m_ovf_d;
            if (tx_valid) begin
                if (ctrl_en) m_wrd++;
                flen = m_len + 1;
                if (tx_end_of_frame) begin
                    if (ctrl_en) begin
                        if (flen >= 8 && flen <= 1024) m_frm++;
                        else m_err++;
                    end
                    m_len = 0;
                end else begin
                    m_len = flen;
                end
            end
            if (ovf_rise && ctrl_en) m_err++;
            if (pulse) begin
                m_frm = 0; m_wrd = 0; m_err = 0;
            end
            m_ovf_d = tx_overflow;
            m_clr_d = ctrl_clr;
        end
        @(posedge user_clk);
        #1;
        check_all("cycle", e);
    endtask

    task automatic send_frame(input int n, input bit en);
        for (int i = 0; i < n; i++) begin
            tx_valid = 1'b1;
            tx_end_of_frame = (i == n - 1);
            ctrl_en = en;
            tick();
        end
        tx_valid = 1'b0;
        tx_end_of_frame = 1'b0;
    endtask

    task automatic do_clear();
        ctrl_clr = 1'b1;
        tick();
        ctrl_clr = 1'b0;
        tick();
    endtask

    task automatic read_check(input string name, input logic [1:0] sel, input longint e);
        ctrl_sel = sel;
        tick();
        check_all(name, e);
    endtask

    initial begin
        vecs[0] = '{len: 10,   en: 1'b1, frm: 1, wrd: 10,   err: 0};
        vecs[1] = '{len: 3,    en: 1'b1, frm: 0, wrd: 3,    err: 1};
        vecs[2] = '{len: 1,    en: 1'b1, frm: 0, wrd: 1,    err: 1};
        vecs[3] = '{len: 7,    en: 1'b1, frm: 0, wrd: 7,    err: 1};
        vecs[4] = '{len: 8,    en: 1'b1, frm: 1, wrd: 8,    err: 0};
        vecs[5] = '{len: 1024, en: 1'b1, frm: 1, wrd: 1024, err: 0};
        vecs[6] = '{len: 1025, en: 1'b1, frm: 0, wrd: 1025, err: 1};
        vecs[7] = '{len: 1100, en: 1'b1, frm: 0, wrd: 1100, err: 1};
        vecs[8] = '{len: 12,   en: 1'b0, frm: 0, wrd: 0,    err: 0};
        vecs[9] = '{len: 300,  en: 1'b1, frm: 1, wrd: 300,  err: 0};

        // Reset state
        user_rst = 1'b1;
        tick();
        tick();
        check_all("rst_out", 0);
        user_rst = 1'b0;
        read_check("rst_frm", 2'd0, 0);
        read_check("rst_wrd", 2'd1, 0);
        read_check("rst_err", 2'd2, 0);
        read_check("rst_status_dis", 2'd3, 0);
        ctrl_en = 1'b1;
        read_check("rst_status_en", 2'd3, 2);

        // Table of single frames, each from a cleared state
        foreach (vecs[i]) begin
            do_clear();
            send_frame(vecs[i].len, vecs[i].en);
            ctrl_en = 1'b1;
            read_check($sformatf("vec%0d_frm", i), 2'd0, vecs[i].frm);
            read_check($sformatf("vec%0d_wrd", i), 2'd1, vecs[i].wrd);
            read_check($sformatf("vec%0d_err", i), 2'd2, vecs[i].err);
        end

        // Output latency: frame counter shows one edge after the eof edge
        do_clear();
        ctrl_sel = 2'd0;
        tick();
        send_frame(10, 1'b1);
        check_all("t1_at_eof", 0);
        tick();
        check_all("t1_after_eof", 1);

        // Runt then oversize back to back
        do_clear();
        send_frame(3, 1'b1);
        send_frame(1100, 1'b1);
        read_check("t2_frm", 2'd0, 0);
        read_check("t2_err", 2'd2, 2);
        read_check("t2_wrd", 2'd1, 1103);

        // Overflow edges count once per rise; coincident with a runt end gives +2
        do_clear();
        ctrl_sel = 2'd2;
        tx_overflow = 1'b1;
        repeat (5) tick();
        tx_overflow = 1'b0;
        repeat (3) tick();
        tx_overflow = 1'b1;
        repeat (2) tick();
        tx_overflow = 1'b0;
        repeat (2) tick();
        check_all("t3_ovf_err", 2);
        tx_valid = 1'b1;
        repeat (2) tick();
        tx_end_of_frame = 1'b1;
        tx_overflow = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_end_of_frame = 1'b0;
        check_all("t3_eof_edge", 2);
        tick();
        check_all("t3_plus2", 4);
        tx_overflow = 1'b0;
        tick();

        // Clear on the eof of a good frame wins; held clear does not re-clear
        do_clear();
        ctrl_sel = 2'd0;
        tx_valid = 1'b1;
        repeat (9) tick();
        tx_end_of_frame = 1'b1;
        ctrl_clr = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_end_of_frame = 1'b0;
        tick();
        check_all("t4_clr_wins", 0);
        send_frame(10, 1'b1);
        repeat (8) tick();
        ctrl_clr = 1'b0;
        read_check("t4_frm", 2'd0, 1);
        read_check("t4_wrd", 2'd1, 10);

        // 256 good frames: wrap, saturate, and full-width variants diverge
        do_clear();
        for (int i = 0; i < 256; i++) send_frame(8, 1'b1);
        read_check("t5_frm", 2'd0, 256);
        read_check("t5_wrd", 2'd1, 2048);
        read_check("t5_err", 2'd2, 0);

        // Enable raised partway through a frame
        do_clear();
        for (int i = 0; i < 12; i++) begin
            tx_valid = 1'b1;
            tx_end_of_frame = (i == 11);
            ctrl_en = (i >= 4);
            tick();
        end
        tx_valid = 1'b0;
        tx_end_of_frame = 1'b0;
        read_check("t6_wrd", 2'd1, 8);
        read_check("t6_frm", 2'd0, 1);

        // Reset in the middle of a frame: the remainder is a fresh runt
        ctrl_en = 1'b1;
        tx_valid = 1'b1;
        repeat (5) tick();
        user_rst = 1'b1;
        tick();
        user_rst = 1'b0;
        tx_valid = 1'b0;
        check_all("t6_rst_out", 0);
        send_frame(6, 1'b1);
        read_check("t6_rst_err", 2'd2, 1);
        read_check("t6_rst_wrd", 2'd1, 6);
        read_check("t6_rst_frm", 2'd0, 0);

        // Status word while in a frame with overflow asserted
        ctrl_sel = 2'd3;
        tx_overflow = 1'b1;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();
        check_all("status_all", 7);
        tx_overflow = 1'b0;
        send_frame(1, 1'b1);
        do_clear();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            tx_valid = ($urandom_range(0, 9) < 7);
            tx_end_of_frame = tx_valid && ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 99) < 8) tx_overflow = ~tx_overflow;
            ctrl_en = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 99) < 3) ctrl_clr = ~ctrl_clr;
            ctrl_sel = 2'($urandom_range(0, 3));
            user_rst = ($urandom_range(0, 999) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
